// File: rtl/debounce_bank_if.sv
// debounce_bank_if: pin-side and event-side signals of a debounce bank.
//   din  : raw asynchronous switch inputs, one bit per channel
//   dout : debounced logical level
//   rise : one-cycle pulse on dout 0->1
//   fall : one-cycle pulse on dout 1->0
//   held : level, long press in progress
//   long : one-cycle pulse when held asserts
// master = the side driving pins (board / bench), slave = the debouncer.
interface debounce_bank_if #(
  parameter int N = 4
) ();
  logic [N-1:0] din;
  logic [N-1:0] dout;
  logic [N-1:0] rise;
  logic [N-1:0] fall;
  logic [N-1:0] held;
  logic [N-1:0] long;

  modport master (output din, input dout, rise, fall, held, long);
  modport slave  (input din, output dout, rise, fall, held, long);
endinterface

// File: rtl/debounce_bank.sv
// debounce_bank: N independent switch debouncers on the 1 MHz clock.
// Per channel: 2-flop synchroniser (optional inversion), stable-time filter,
// rise/fall pulses, and a long-press detector.
//   clk_1M : 1 MHz clock, rising edge
//   rst    : asynchronous, active-high reset
//   bus    : debounce_bank_if.slave (din in; dout/rise/fall/held/long out)
// All outputs are registered.

module debounce_lane #(
  parameter int DEBOUNCE_CYCLES = 20_000,
  parameter int HOLD_CYCLES     = 1_000_000,
  parameter int ACTIVE_LOW      = 0
) (
  input  logic clk_1M,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall,
  output logic held,
  output logic long
);
  localparam int CW = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic INV = (ACTIVE_LOW != 0);

  logic          s0, s1;
  logic [CW-1:0] cnt;
  logic          fire;

  // s1 has disagreed with dout for DEBOUNCE_CYCLES consecutive samples
  assign fire = (s1 != dout) && (cnt == CNT_MAX);

  always_ff @(posedge clk_1M or posedge rst) begin
    if (rst) begin
      s0   <= 1'b0;
      s1   <= 1'b0;
      cnt  <= '0;
      dout <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      s0   <= din ^ INV;
      s1   <= s0;
      rise <= fire & s1;
      fall <= fire & ~s1;
      if (s1 == dout)
        cnt <= '0;
      else if (fire) begin
        dout <= s1;
        cnt  <= '0;
      end else
        cnt <= cnt + CW'(1);
    end
  end

  if (HOLD_CYCLES == 0) begin : g_no_hold
    assign held = 1'b0;
    assign long = 1'b0;
  end else begin : g_hold
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES - 1);

    logic [HW-1:0] hcnt;
    logic          dout_nxt, rise_nxt;

    // Decide on the level dout takes this edge, so held drops on the same
    // edge as fall and the count restarts on the rise edge.
    assign dout_nxt = fire ? s1 : dout;
    assign rise_nxt = fire & s1;

    always_ff @(posedge clk_1M or posedge rst) begin
      if (rst) begin
        hcnt <= '0;
        held <= 1'b0;
        long <= 1'b0;
      end else begin
        long <= 1'b0;
        if (!dout_nxt || rise_nxt) begin
          hcnt <= '0;
          held <= 1'b0;
        end else if (!held && hcnt == HOLD_MAX) begin
          held <= 1'b1;
          long <= 1'b1;
        end else if (!held)
          hcnt <= hcnt + HW'(1);
        // held: hcnt frozen until release
      end
    end
  end
endmodule

module debounce_bank #(
  parameter int N               = 4,
  parameter int DEBOUNCE_CYCLES = 20_000,
  parameter int HOLD_CYCLES     = 1_000_000,
  parameter int ACTIVE_LOW      = 0
) (
  input  logic            clk_1M,
  input  logic            rst,
  debounce_bank_if.slave  bus
);
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_param
    $error("debounce_bank: DEBOUNCE_CYCLES must be >= 1");
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    debounce_lane #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .HOLD_CYCLES     (HOLD_CYCLES),
      .ACTIVE_LOW      (ACTIVE_LOW)
    ) u_lane (
      .clk_1M (clk_1M),
      .rst    (rst),
      .din    (bus.din[i]),
      .dout   (bus.dout[i]),
      .rise   (bus.rise[i]),
      .fall   (bus.fall[i]),
      .held   (bus.held[i]),
      .long   (bus.long[i])
    );
  end
endmodule

// File: tb/tb_debounce_bank.sv
// tb_debounce_bank: directed, table-driven bench for debounce_bank.
// Three instances: main (N=2, DB=4, HOLD=10), active-low copy, and a
// DB=1 / HOLD=0 copy. Outputs are sampled 1 time unit after each edge.
module tb_debounce_bank;
  logic       clk_1M = 1'b0;
  logic       rst    = 1'b1;
  logic [1:0] din_a  = 2'b00;
  logic [1:0] din_b  = 2'b11;

  always #5 clk_1M = ~clk_1M;

  debounce_bank_if #(.N(2)) bus_a ();
  debounce_bank_if #(.N(2)) bus_b ();
  debounce_bank_if #(.N(2)) bus_c ();

  assign bus_a.din = din_a;
  assign bus_b.din = din_b;
  assign bus_c.din = din_a;

  debounce_bank #(.N(2), .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(10), .ACTIVE_LOW(0))
    u_dut  (.clk_1M(clk_1M), .rst(rst), .bus(bus_a));
  debounce_bank #(.N(2), .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(10), .ACTIVE_LOW(1))
    u_inv  (.clk_1M(clk_1M), .rst(rst), .bus(bus_b));
  debounce_bank #(.N(2), .DEBOUNCE_CYCLES(1), .HOLD_CYCLES(0), .ACTIVE_LOW(0))
    u_fast (.clk_1M(clk_1M), .rst(rst), .bus(bus_c));

  // {dout, rise, fall, held, long}, 2 bits each
  logic [9:0] obs_a, obs_b, obs_c;
  assign obs_a = {bus_a.dout, bus_a.rise, bus_a.fall, bus_a.held, bus_a.long};
  assign obs_b = {bus_b.dout, bus_b.rise, bus_b.fall, bus_b.held, bus_b.long};
  assign obs_c = {bus_c.dout, bus_c.rise, bus_c.fall, bus_c.held, bus_c.long};

  typedef struct {
    logic [1:0] din;
    logic [1:0] dout, rise, fall, held, lng;
  } vec_t;

  vec_t tbl [28];
  int n_chk  = 0;
  int n_pass = 0;

  function automatic logic [9:0] ex(logic [1:0] d, r, f, h, l);
    return {d, r, f, h, l};
  endfunction

  task automatic step();
    @(posedge clk_1M);
    #1;
  endtask

  task automatic chk(string nm, logic [9:0] act, logic [9:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b want %b (dout,rise,fall,held,long)", nm, act, exp);
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    din_a = 2'b00;
    din_b = 2'b11;
    repeat (3) step();
    rst = 1'b0;
    repeat (2) step();
  endtask

  initial begin
    // press / long-press / release on ch0, ch1 idle; index i == edge Ei
    for (int i = 0;  i < 5;  i++) tbl[i] = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    tbl[5] = '{2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00};
    for (int i = 6;  i < 15; i++) tbl[i] = '{2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
    tbl[15] = '{2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 2'b01};
    for (int i = 16; i < 20; i++) tbl[i] = '{2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00};
    for (int i = 20; i < 25; i++) tbl[i] = '{2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00};
    tbl[25] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00};
    for (int i = 26; i < 28; i++) tbl[i] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};

    // reset state, checked while rst is still high
    rst = 1'b1;
    repeat (2) step();
    chk("reset_a", obs_a, '0);
    chk("reset_b", obs_b, '0);
    chk("reset_c", obs_c, '0);
    rst = 1'b0;
    repeat (2) step();

    // table: basic press, long press, release
    for (int i = 0; i < 28; i++) begin
      din_a = tbl[i].din;
      step();
      chk($sformatf("vec_E%0d", i), obs_a,
          ex(tbl[i].dout, tbl[i].rise, tbl[i].fall, tbl[i].held, tbl[i].lng));
    end

    // glitch of 3 samples is rejected
    do_reset();
    din_a = 2'b01;
    repeat (3) step();
    din_a = 2'b00;
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("glitch3_%0d", i), obs_a, '0);
    end
    // 4-cycle pulse passes, then releases
    din_a = 2'b01;
    repeat (4) step();
    din_a = 2'b00;
    step();
    chk("pulse4_E4", obs_a, '0);
    step();
    chk("pulse4_E5", obs_a, ex(2'b01, 2'b01, 2'b00, 2'b00, 2'b00));
    step();
    chk("pulse4_E6", obs_a, ex(2'b01, 2'b00, 2'b00, 2'b00, 2'b00));
    repeat (2) step();
    chk("pulse4_E8", obs_a, ex(2'b01, 2'b00, 2'b00, 2'b00, 2'b00));
    step();
    chk("pulse4_E9", obs_a, ex(2'b00, 2'b00, 2'b01, 2'b00, 2'b00));

    // active-low: both pins pulled low together
    do_reset();
    din_b = 2'b00;
    repeat (5) step();
    chk("inv_E4", obs_b, '0);
    step();
    chk("inv_E5", obs_b, ex(2'b11, 2'b11, 2'b00, 2'b00, 2'b00));
    step();
    chk("inv_E6", obs_b, ex(2'b11, 2'b00, 2'b00, 2'b00, 2'b00));
    din_b = 2'b11;

    // reset mid-count (cnt == 2 after E3)
    do_reset();
    din_a = 2'b01;
    repeat (4) step();
    rst = 1'b1;
    #1;
    chk("rst_midcount", obs_a, '0);
    step();
    rst = 1'b0;
    repeat (5) step();
    chk("rst_fresh_E4", obs_a, '0);
    step();
    chk("rst_fresh_E5", obs_a, ex(2'b01, 2'b01, 2'b00, 2'b00, 2'b00));
    repeat (10) step();
    chk("rst_hold_E15", obs_a, ex(2'b01, 2'b00, 2'b00, 2'b01, 2'b01));
    step();
    chk("rst_hold_E16", obs_a, ex(2'b01, 2'b00, 2'b00, 2'b01, 2'b00));
    // reset while held
    rst = 1'b1;
    #1;
    chk("rst_midhold", obs_a, '0);
    step();
    chk("rst_midhold_edge", obs_a, '0);
    rst = 1'b0;
    repeat (5) step();
    chk("rst_again_E4", obs_a, '0);
    step();
    chk("rst_again_E5", obs_a, ex(2'b01, 2'b01, 2'b00, 2'b00, 2'b00));

    // DEBOUNCE_CYCLES=1, HOLD_CYCLES=0
    do_reset();
    din_a = 2'b01;
    repeat (2) step();
    chk("fast_E1", obs_c, '0);
    step();
    chk("fast_E2", obs_c, ex(2'b01, 2'b01, 2'b00, 2'b00, 2'b00));
    for (int i = 0; i < 15; i++) begin
      step();
      chk($sformatf("fast_nohold_%0d", i), obs_c, ex(2'b01, 2'b00, 2'b00, 2'b00, 2'b00));
    end
    din_a = 2'b00;
    repeat (2) step();
    chk("fast_rel_E1", obs_c, ex(2'b01, 2'b00, 2'b00, 2'b00, 2'b00));
    step();
    chk("fast_rel_E2", obs_c, ex(2'b00, 2'b00, 2'b01, 2'b00, 2'b00));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/debounce_bank.md
# debounce_bank

Parametrised multi-channel debouncer for push-buttons and mechanical switches on the 1 MHz system clock. Each channel has a two-stage synchroniser, optional polarity inversion, a stable-time filter, one-cycle press/release pulses and a long-press detector. It sits between board pins and the control FSMs, so those FSMs see clean levels and single-cycle events.

## Interface
- N, default 4: number of independent channels.
- DEBOUNCE_CYCLES, default 20_000: consecutive stable synchronised samples required before the output changes (20 ms at 1 MHz). Legal range is 1 or more.
- HOLD_CYCLES, default 1_000_000: cycles the debounced level must stay 1 before a long press is flagged (1 s). A value of 0 disables the detector: held and long stay 0.
- ACTIVE_LOW, default 0: when 1, each din bit is inverted before the filter, so a pin at 0 reads as logical 1 (pressed).
- clk_1M, input, 1 bit: 1 MHz clock. All logic is rising-edge.
- rst, input, 1 bit: reset, asynchronous, active-high.
- din, input, N bits: raw asynchronous switch inputs.
- dout, output, N bits: debounced logical level.
- rise, output, N bits: one-cycle pulse when dout goes 0→1.
- fall, output, N bits: one-cycle pulse when dout goes 1→0.
- held, output, N bits: level. It is 1 while a long press is in progress.
- long, output, N bits: one-cycle pulse when held asserts.

## Operation
- Every channel is identical and independent. There is no sharing or arbitration between channels.
- Synchroniser: s0 ← din^ACTIVE_LOW, then s1 ← s0. All filter logic uses s1 only.
- Stable counter cnt is clog2(DEBOUNCE_CYCLES+1) bits wide. Each edge it does one of the following:
  - If s1 == dout: cnt ← 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: dout ← s1 and cnt ← 0. On the same edge, rise ← s1 and fall ← ~s1.
  - Else: cnt ← cnt+1.
- rise and fall are 0 on every edge where dout does not change. They are never both 1.
- A glitch shorter than DEBOUNCE_CYCLES samples is fully rejected. A single sample matching dout clears cnt, and the count restarts from 0.
- Hold counter hcnt is clog2(HOLD_CYCLES+1) bits wide. Each edge it does one of the following:
  - If dout == 0, or rise is being asserted on this edge: hcnt ← 0 and held ← 0.
  - Else if held == 0 and hcnt == HOLD_CYCLES-1: held ← 1 and long ← 1.
  - Else if held == 0: hcnt ← hcnt+1.
  - Once held is 1, hcnt freezes. The counter never wraps.
- long is 0 on every other edge.
- On a release, held drops on the same edge that dout drops and fall asserts.

## Timing
- Reset: s0, s1, cnt, hcnt, dout, rise, fall, held and long are all 0. dout = 0 means released in logical polarity.
- If rst is asserted mid-count or mid-hold, all state clears immediately and no pulse is emitted. After release, a held-down input is treated as a fresh press: it needs the full DEBOUNCE_CYCLES and produces a rise.
- Latency: din is sampled at edge E0 and is stable afterwards. s1 updates at E1. dout, rise or fall update at edge E(DEBOUNCE_CYCLES+1).
- The long pulse comes HOLD_CYCLES edges after the rise edge. The same delay applies to held.
- All outputs are registered. There is no combinational path from din to any output.
- With DEBOUNCE_CYCLES = 1, dout follows s1 with a one-cycle delay and still produces rise and fall pulses.
- Elaboration must reject DEBOUNCE_CYCLES = 0.

## Test plan
- Test parameters: N=2, DEBOUNCE_CYCLES=4, HOLD_CYCLES=10, ACTIVE_LOW=0.
- Basic press: reset, then set din[0]=1 before edge E0. Required: dout[0]=1 and rise[0]=1 after E5, rise[0]=0 after E6, and channel 1 all 0 throughout.
- Glitch reject: din[0] pulses high for 3 cycles, then returns low. Required: dout[0] stays 0 with no rise. A following 4-cycle high pulse must produce dout[0]=1 at E5 relative to its start.
- Long press: hold din[0]=1. Required: held[0]=1 and long[0]=1 (one cycle) 10 edges after the rise. On release, fall[0] and held[0]=0 occur on the same edge, with no second long pulse.
- Simultaneous channels and polarity: with ACTIVE_LOW=1 and din=2'b11 idle, drive din=2'b00 on both channels at E0. Required: rise=2'b11 on the same edge E5.
- Reset mid-operation: assert rst while cnt=2 and while held=1. Required: all outputs 0 immediately. After rst drops with din still high, rise reappears 5 edges later.
